// File: rtl/alu_seq_if.sv
// alu_seq_if: command handshake from decode plus the ALU control bundle driven by alu_sequencer.
interface alu_seq_if;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [2:0]  req_bit;
    logic        req_ready;
    logic        stall;
    logic        alu_out_wr;
    logic [4:0]  alu_cntl;
    logic [2:0]  bit_op;
    logic [3:0]  a_wr_sel;
    logic        wb_strobe;
    logic        done;
    logic        err;
    logic [15:0] op_count;
    modport master (
        output req_valid, req_op, req_bit, stall,
        input  req_ready, alu_out_wr, alu_cntl, bit_op, a_wr_sel, wb_strobe, done, err, op_count
    );
    modport slave (
        input  req_valid, req_op, req_bit, stall,
        output req_ready, alu_out_wr, alu_cntl, bit_op, a_wr_sel, wb_strobe, done, err, op_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps one decoded ALU command through EXEC (and WB for 2-step ops), driving ALU strobes.
module alu_sequencer (
    input  logic      core_clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    localparam logic [4:0] cntl_tab [16] = '{
        5'b00101, 5'b01110, 5'b01100, 5'b10000, 5'b01011, 5'b01000, 5'b00100, 5'b00000,
        5'b01111, 5'b01101, 5'b01001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000
    };
    state_t      state, nxt;
    logic [3:0]  op;
    logic [2:0]  bit_idx;
    logic [15:0] count;
    logic        illegal, two_step;
    assign illegal  = op > 4'd10;
    assign two_step = !illegal && op >= 4'd6;
    assign bus.req_ready = state == IDLE;
    assign bus.op_count  = count;
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op      <= '0;
            bit_idx <= '0;
            count   <= '0;
        end else begin
            state <= nxt;
            if (bus.req_valid && bus.req_ready) begin
                op      <= bus.req_op;
                bit_idx <= bus.req_bit;
            end
            if (bus.done) count <= count + 16'd1;
        end
    end
    always_comb begin
        nxt            = state;
        bus.alu_out_wr = 1'b0;
        bus.a_wr_sel   = '0;
        bus.wb_strobe  = 1'b0;
        bus.done       = 1'b0;
        bus.err        = 1'b0;
        bus.alu_cntl   = (state == IDLE) ? 5'd0 : cntl_tab[op];
        bus.bit_op     = (state != IDLE && (op == 4'd5 || op == 4'd8)) ? bit_idx : 3'd0;
        case (state)
            IDLE: nxt = bus.req_valid ? EXEC : IDLE;
            EXEC: if (!bus.stall) begin
                bus.alu_out_wr = !illegal;
                bus.a_wr_sel   = (op < 4'd4) ? 4'b0001 << op[1:0] : 4'b0000;
                bus.done       = !two_step;
                bus.err        = illegal;
                nxt            = two_step ? WB : IDLE;
            end
            WB: if (!bus.stall) begin
                bus.wb_strobe = 1'b1;
                bus.done      = 1'b1;
                nxt           = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule
